// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer: funct7/funct3 codes
// and the controller state encoding.
package muldiv_seq_ctrl_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE     = 2'd0,
    MD_MUL_WAIT = 2'd1,
    MD_DIV_RUN  = 2'd2,
    MD_DONE     = 2'd3
  } md_state_e;

  function automatic logic is_muldiv_funct7(input logic [6:0] funct7);
    return funct7 == FUNCT7_MULDIV;
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Iterative restoring divider datapath on unsigned magnitudes: one quotient bit
// per step, MSB first.
module md_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_reg;
  logic [XLEN:0]   rem_reg;
  logic [XLEN-1:0] dvs_reg;

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic            fits;
  logic [XLEN-1:0] quo_step;
  logic [XLEN:0]   rem_step;

  always_comb begin
    shifted  = {rem_reg, quo_reg[XLEN-1]};
    diff     = shifted - {2'b00, dvs_reg};
    fits     = ~diff[XLEN+1];
    rem_step = fits ? diff[XLEN:0] : shifted[XLEN:0];
    quo_step = {quo_reg[XLEN-2:0], fits};
  end

  // Outputs look ahead through the step in progress so the controller can
  // capture the final result on the same edge as the last step.
  assign quotient  = step ? quo_step : quo_reg;
  assign remainder = step ? rem_step[XLEN-1:0] : rem_reg[XLEN-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quo_reg <= '0;
      rem_reg <= '0;
      dvs_reg <= '0;
    end else if (load) begin
      quo_reg <= dividend;
      rem_reg <= '0;
      dvs_reg <= divisor;
    end else if (step) begin
      quo_reg <= quo_step;
      rem_reg <= rem_step;
    end
  end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// RV32M sequencing controller: accepts one M op from EX, stalls the pipeline,
// waits out the registered multiplier or steps the divider, returns one result.
module muldiv_seq_ctrl
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            md_req,
  input  logic [2:0]      md_funct3,
  input  logic [XLEN-1:0] md_rs1,
  input  logic [XLEN-1:0] md_rs2,
  input  logic            md_kill,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic            md_busy
);

  localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  md_state_e         state_reg, state_next;
  logic [CNT_W-1:0]  counter_reg, counter_next;
  logic [2:0]        f3_reg;
  logic              q_neg_reg, r_neg_reg;
  logic [2*XLEN-1:0] prod_reg;
  logic [XLEN-1:0]   result_reg, result_next;

  logic a_signed, b_signed, is_div, div_signed;
  logic div_by_zero, div_ovf, special;
  logic a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b, special_result;
  logic [2*XLEN-1:0] a_wide, b_wide, prod_wide;
  logic accept, abort, div_load, div_step, load_result;
  logic [XLEN-1:0] div_quo, div_rem;

  always_comb begin
    a_signed   = 1'b0;
    b_signed   = 1'b0;
    is_div     = 1'b0;
    div_signed = 1'b0;
    case (md_funct3)
      MD_MUL, MD_MULH: begin a_signed = 1'b1; b_signed = 1'b1; end
      MD_MULHSU:       a_signed = 1'b1;
      MD_MULHU:        ;
      MD_DIV, MD_REM:  begin is_div = 1'b1; div_signed = 1'b1; end
      MD_DIVU, MD_REMU: is_div = 1'b1;
      default:         ;
    endcase
  end

  // Sign extension to the full product width keeps the low 2*XLEN bits exact.
  assign a_wide    = {{XLEN{a_signed & md_rs1[XLEN-1]}}, md_rs1};
  assign b_wide    = {{XLEN{b_signed & md_rs2[XLEN-1]}}, md_rs2};
  assign prod_wide = a_wide * b_wide;

  assign div_by_zero = (md_rs2 == '0);
  assign div_ovf     = div_signed & (md_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&md_rs2);
  assign special     = div_by_zero | div_ovf;
  assign a_neg       = div_signed & md_rs1[XLEN-1];
  assign b_neg       = div_signed & md_rs2[XLEN-1];
  assign abs_a       = a_neg ? -md_rs1 : md_rs1;
  assign abs_b       = b_neg ? -md_rs2 : md_rs2;

  always_comb begin
    if (div_by_zero) special_result = md_funct3[1] ? md_rs1 : '1;
    else             special_result = md_funct3[1] ? '0 : md_rs1;
  end

  assign accept   = (state_reg == MD_IDLE) & md_req & ~md_kill;
  assign abort    = md_kill | ~md_req;
  assign div_load = accept & is_div & ~special;
  assign div_step = (state_reg == MD_DIV_RUN) & ~abort;

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    case (state_reg)
      MD_IDLE: begin
        if (accept) begin
          if (!is_div) begin
            state_next   = MD_MUL_WAIT;
            counter_next = CNT_W'(MUL_LAT);
          end else if (special) begin
            state_next   = MD_DONE;
          end else begin
            state_next   = MD_DIV_RUN;
            counter_next = CNT_W'(XLEN);
          end
        end
      end
      MD_MUL_WAIT, MD_DIV_RUN: begin
        if (abort) begin
          state_next   = MD_IDLE;
          counter_next = '0;
        end else begin
          counter_next = counter_reg - CNT_W'(1);
          if (counter_reg == CNT_W'(1)) state_next = MD_DONE;
        end
      end
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    result_next = result_reg;
    case (state_reg)
      MD_IDLE:     result_next = special_result;
      MD_MUL_WAIT: result_next = (f3_reg == MD_MUL) ? prod_reg[XLEN-1:0]
                                                    : prod_reg[2*XLEN-1:XLEN];
      MD_DIV_RUN:  result_next = f3_reg[1] ? (r_neg_reg ? -div_rem : div_rem)
                                           : (q_neg_reg ? -div_quo : div_quo);
      default:     ;
    endcase
  end

  // md_result must already be valid in the DONE cycle, so it is captured on entry.
  assign load_result = (state_next == MD_DONE) & (state_reg != MD_DONE);

  md_div_core #(.XLEN(XLEN)) u_div_core (
    .clk       (clk),
    .rstn      (rstn),
    .load      (div_load),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= MD_IDLE;
      counter_reg <= '0;
      f3_reg      <= '0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      prod_reg    <= '0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      if (accept) begin
        f3_reg    <= md_funct3;
        q_neg_reg <= a_neg ^ b_neg;
        r_neg_reg <= a_neg;
        prod_reg  <= prod_wide;
      end
      if (load_result) result_reg <= result_next;
    end
  end

  assign md_stall  = rstn & md_req & ~md_kill & (state_reg != MD_DONE);
  assign md_done   = (state_reg == MD_DONE) & md_req & ~md_kill;
  assign md_busy   = (state_reg != MD_IDLE);
  assign md_result = result_reg;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl: vector table of ops with hand-computed
// results and latencies, plus kill and reset sequences.
module tb_muldiv_seq_ctrl;
  import muldiv_seq_ctrl_pkg::*;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;
  localparam int NV      = 19;

  logic            clk = 1'b0;
  logic            rstn;
  logic            md_req;
  logic [2:0]      md_funct3;
  logic [XLEN-1:0] md_rs1, md_rs2;
  logic            md_kill;
  logic            md_stall, md_done, md_busy;
  logic [XLEN-1:0] md_result;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[NV];

  muldiv_seq_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .md_req    (md_req),
    .md_funct3 (md_funct3),
    .md_rs1    (md_rs1),
    .md_rs2    (md_rs2),
    .md_kill   (md_kill),
    .md_stall  (md_stall),
    .md_done   (md_done),
    .md_result (md_result),
    .md_busy   (md_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (md_done) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int  c;
    int  stalls;
    bit  seen;
    md_req    = 1'b1;
    md_funct3 = f3;
    md_rs1    = a;
    md_rs2    = b;
    md_kill   = 1'b0;
    c = 0; stalls = 0; seen = 1'b0;
    while (!seen && c < 200) begin
      #1;
      if (md_stall) stalls++;
      if (md_done) begin
        seen = 1'b1;
        chk({name, " latency"}, c, lat);
        chk({name, " result"}, md_result, exp);
      end
      @(posedge clk); #1;
      c++;
    end
    chk({name, " done_seen"}, {31'b0, seen}, 32'd1);
    chk({name, " stall_cycles"}, stalls, lat);
    $display("op %s f3=%0d a=0x%08h b=0x%08h exp=0x%08h lat=%0d", name, f3, a, b, exp, lat);
    md_req = 1'b0;
  endtask

  initial begin
    int cnt_before;

    vecs[0]  = '{MD_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 3};
    vecs[1]  = '{MD_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 3};
    vecs[2]  = '{MD_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 3};
    vecs[3]  = '{MD_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 3};
    vecs[4]  = '{MD_MUL,    32'h12345678,   32'h00000010, 32'h23456780, 3};
    vecs[5]  = '{MD_DIV,    32'hFFFFFFEC,   32'd6,        32'hFFFFFFFD, 33};
    vecs[6]  = '{MD_REM,    32'hFFFFFFEC,   32'd6,        32'hFFFFFFFE, 33};
    vecs[7]  = '{MD_DIVU,   32'd100,        32'd7,        32'd14,       33};
    vecs[8]  = '{MD_REMU,   32'd100,        32'd7,        32'd2,        33};
    vecs[9]  = '{MD_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[10] = '{MD_REM,    32'd7,          32'hFFFFFFFE, 32'd1,        33};
    vecs[11] = '{MD_DIVU,   32'h80000000,   32'hFFFFFFFF, 32'd0,        33};
    vecs[12] = '{MD_REMU,   32'h80000000,   32'hFFFFFFFF, 32'h80000000, 33};
    vecs[13] = '{MD_DIV,    32'd5,          32'd0,        32'hFFFFFFFF, 1};
    vecs[14] = '{MD_REMU,   32'd5,          32'd0,        32'd5,        1};
    vecs[15] = '{MD_REM,    32'hFFFFFFEC,   32'd0,        32'hFFFFFFEC, 1};
    vecs[16] = '{MD_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
    vecs[17] = '{MD_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
    vecs[18] = '{MD_MULHU,  32'h00010000,   32'h00010000, 32'd1,        3};

    // Reset state, with md_req high to confirm md_stall stays low in reset.
    rstn = 1'b0; md_req = 1'b1; md_funct3 = 3'd0; md_rs1 = '0; md_rs2 = '0; md_kill = 1'b0;
    #2;
    chk("reset stall",  {31'b0, md_stall}, 32'd0);
    chk("reset done",   {31'b0, md_done},  32'd0);
    chk("reset busy",   {31'b0, md_busy},  32'd0);
    chk("reset result", md_result,         32'd0);
    md_req = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Kill at divider step 10.
    cnt_before = done_cnt;
    md_req = 1'b1; md_funct3 = MD_DIV; md_rs1 = 32'hFFFFFFEC; md_rs2 = 32'd6;
    repeat (10) @(posedge clk);
    #1; md_kill = 1'b1; #1;
    chk("kill stall",       {31'b0, md_stall}, 32'd0);
    chk("kill done",        {31'b0, md_done},  32'd0);
    chk("kill busy_during", {31'b0, md_busy},  32'd1);
    chk("kill result_hold", md_result,         vecs[NV-1].exp);
    $display("seq kill_div_step10");
    @(posedge clk); #1;
    md_kill = 1'b0; md_req = 1'b0; #1;
    chk("kill busy_after", {31'b0, md_busy}, 32'd0);
    chk("kill no_done",    done_cnt,         cnt_before);
    @(posedge clk); #1;
    run_op("kill_then_mul", MD_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 3);

    // Kill coinciding with DONE suppresses md_done.
    cnt_before = done_cnt;
    md_req = 1'b1; md_funct3 = MD_MUL; md_rs1 = 32'd3; md_rs2 = 32'd5;
    repeat (3) @(posedge clk);
    #1; md_kill = 1'b1; #1;
    chk("kill_done busy", {31'b0, md_busy}, 32'd1);
    chk("kill_done done", {31'b0, md_done}, 32'd0);
    $display("seq kill_in_done");
    @(posedge clk); #1;
    md_kill = 1'b0; md_req = 1'b0; #1;
    chk("kill_done busy_after", {31'b0, md_busy}, 32'd0);
    chk("kill_done no_done",    done_cnt,         cnt_before);

    // Asynchronous reset in the middle of DIV_RUN.
    @(posedge clk); #1;
    md_req = 1'b1; md_funct3 = MD_DIVU; md_rs1 = 32'd100; md_rs2 = 32'd7;
    repeat (5) @(posedge clk);
    #3; rstn = 1'b0; #1;
    chk("rst_mid stall",  {31'b0, md_stall}, 32'd0);
    chk("rst_mid done",   {31'b0, md_done},  32'd0);
    chk("rst_mid busy",   {31'b0, md_busy},  32'd0);
    chk("rst_mid result", md_result,         32'd0);
    chk("rst_mid no_done", done_cnt,         cnt_before);
    $display("seq reset_mid_div");
    md_req = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    cnt_before = done_cnt;
    run_op("b2b_mul", MD_MUL, 32'd6, 32'd7, 32'd42, 3);
    run_op("b2b_div", MD_DIV, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, 33);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b done_count", done_cnt, cnt_before + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
